dm_responder: RTL and testbench



---
 rtl/dm_responder.sv | 126 ++++++++++++
 tb/tb_dm_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency,
// read data and fault flag returned on a one-cycle ack pulse.
module dm_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic        clk,
    input  logic        INT,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] off;
    logic [31:0] idx;
    logic        fault;
    logic        mem_we;

    // Decode works on the captured address so bus changes while busy are inert.
    always_comb begin
        off   = addr_q - BASE;
        idx   = off >> 2;
        fault = (addr_q[1:0] != 2'b00) || (addr_q < BASE) ||
                (idx >= 32'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ACK;
                    if (fault) begin
                        err_d = 1'b1;
                    end else if (we_q) begin
                        mem_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem_q[idx[AW-1:0]];
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge INT) begin
        if (INT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; a reset racing the commit edge still blocks it.
    always_ff @(posedge clk) begin
        if (mem_we && !INT) begin
            mem_q[idx[AW-1:0]] <= wdata_q;
        end
    end

    assign ack   = (state_q == ACK);
    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: latency, faults, busy-ignore, resets,
// across four parameterisations sharing one clock and reset.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        INT = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  req_v = '0;
    logic [3:0]  ack_v;
    logic [3:0]  err_v;
    logic [3:0]  busy_v;
    logic [31:0] rdata_v [4];

    int n_tot = 0;
    int n_bad = 0;
    int na;
    int at [3];
    logic [31:0] seen [3];

    always #5 clk = ~clk;

    dm_responder u_dut (
        .clk(clk), .INT(INT), .req(req_v[0]), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[0]), .ack(ack_v[0]),
        .err(err_v[0]), .busy(busy_v[0])
    );

    dm_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .INT(INT), .req(req_v[1]), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[1]), .ack(ack_v[1]),
        .err(err_v[1]), .busy(busy_v[1])
    );

    dm_responder #(.LATENCY(5)) u_l5 (
        .clk(clk), .INT(INT), .req(req_v[2]), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[2]), .ack(ack_v[2]),
        .err(err_v[2]), .busy(busy_v[2])
    );

    dm_responder #(.BASE(32'h100)) u_b (
        .clk(clk), .INT(INT), .req(req_v[3]), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_v[3]), .ack(ack_v[3]),
        .err(err_v[3]), .busy(busy_v[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 with the selected instance in IDLE.
    task automatic run(input string tag, input int s, input int lat,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err);
        int got_lat;
        logic [31:0] rd;
        logic e;
        got_lat = 0;
        rd = '0;
        e = 1'b0;
        we = w;
        addr = a;
        wdata = d;
        req_v[s] = 1'b1;
        @(posedge clk); #1;
        req_v[s] = 1'b0;
        chk({tag, "_busy"}, 32'(busy_v[s]), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack_v[s]) begin
                got_lat = i;
                rd = rdata_v[s];
                e = err_v[s];
                break;
            end
        end
        chk({tag, "_lat"}, 32'(got_lat), 32'(lat));
        chk({tag, "_rd"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_idle"}, 32'(busy_v[s]), 32'd0);
    endtask

    // Continuous read request; accept, ack and re-accept in IDLE repeat.
    task automatic sweep(input string tag, input int s, input int lat,
                         input logic [31:0] exp);
        int k_acks;
        int first [3];
        k_acks = 0;
        first = '{0, 0, 0};
        we = 1'b0;
        addr = 32'h0;
        req_v[s] = 1'b1;
        for (int k = 1; k <= 3 * (lat + 2); k++) begin
            @(posedge clk); #1;
            chk({tag, "_busy"}, 32'(busy_v[s]),
                (((k - 1) % (lat + 2)) < (lat + 1)) ? 32'd1 : 32'd0);
            if (ack_v[s]) begin
                if (k_acks < 3) first[k_acks] = k;
                k_acks++;
                chk({tag, "_rd"}, rdata_v[s], exp);
            end
        end
        req_v[s] = 1'b0;
        chk({tag, "_n"}, 32'(k_acks), 32'd3);
        chk({tag, "_a0"}, 32'(first[0]), 32'(lat + 1));
        chk({tag, "_a1"}, 32'(first[1]), 32'(2 * lat + 3));
        chk({tag, "_a2"}, 32'(first[2]), 32'(3 * lat + 5));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk("rst_ack", 32'(ack_v[s]), 32'd0);
            chk("rst_busy", 32'(busy_v[s]), 32'd0);
            chk("rst_rd", rdata_v[s], 32'd0);
            chk("rst_err", 32'(err_v[s]), 32'd0);
        end
        INT = 1'b0;
        @(posedge clk); #1;

        run("wr8", 0, 2, 1'b1, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        run("rd8", 0, 2, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);
        run("wr0", 0, 2, 1'b1, 32'h0, 32'h12345678, 32'h12345678, 1'b0);
        run("mis", 0, 2, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
        run("oob", 0, 2, 1'b1, 32'h400, 32'hBAD, 32'h0, 1'b1);
        run("rd0", 0, 2, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
        run("wtop", 0, 2, 1'b1, 32'h3FC, 32'hCAFE0001, 32'hCAFE0001, 1'b0);
        run("rtop", 0, 2, 1'b0, 32'h3FC, 32'h0, 32'hCAFE0001, 1'b0);

        // Bus changes while busy; req dropped during ack so only one ack.
        we = 1'b1; addr = 32'h4; wdata = 32'h11; req_v[0] = 1'b1;
        @(posedge clk); #1;
        wdata = 32'h22;
        na = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (ack_v[0]) begin
                na++;
                chk("ign_rd", rdata_v[0], 32'h11);
                req_v[0] = 1'b0;
            end
        end
        chk("ign_n", 32'(na), 32'd1);
        run("ign_chk", 0, 2, 1'b0, 32'h4, 32'h0, 32'h11, 1'b0);

        // Held req is re-accepted on the first IDLE edge.
        we = 1'b1; addr = 32'h4; wdata = 32'h33; req_v[0] = 1'b1;
        @(posedge clk); #1;
        wdata = 32'h44;
        na = 0;
        at = '{0, 0, 0};
        seen = '{32'h0, 32'h0, 32'h0};
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack_v[0]) begin
                if (na < 3) begin
                    at[na] = k;
                    seen[na] = rdata_v[0];
                end
                na++;
                if (na == 2) req_v[0] = 1'b0;
            end
        end
        req_v[0] = 1'b0;
        chk("hold_n", 32'(na), 32'd2);
        chk("hold_a0", 32'(at[0]), 32'd2);
        chk("hold_a1", 32'(at[1]), 32'd6);
        chk("hold_r0", seen[0], 32'h33);
        chk("hold_r1", seen[1], 32'h44);
        run("hold_chk", 0, 2, 1'b0, 32'h4, 32'h0, 32'h44, 1'b0);

        // Async reset while ack is high clears outputs before any edge.
        we = 1'b1; addr = 32'h10; wdata = 32'h77; req_v[0] = 1'b1;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ar_ack_pre", 32'(ack_v[0]), 32'd1);
        chk("ar_rd_pre", rdata_v[0], 32'h77);
        #2 INT = 1'b1;
        #1;
        chk("ar_ack", 32'(ack_v[0]), 32'd0);
        chk("ar_busy", 32'(busy_v[0]), 32'd0);
        chk("ar_rd", rdata_v[0], 32'd0);
        chk("ar_err", 32'(err_v[0]), 32'd0);
        #1 INT = 1'b0;
        @(posedge clk); #1;
        run("ar_keep", 0, 2, 1'b0, 32'h10, 32'h0, 32'h77, 1'b0);

        // Reset during WAIT aborts the write and suppresses the ack.
        run("wrC", 0, 2, 1'b1, 32'hC, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        we = 1'b1; addr = 32'hC; wdata = 32'h55; req_v[0] = 1'b1;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        chk("mr_busy_pre", 32'(busy_v[0]), 32'd1);
        #2 INT = 1'b1;
        #1;
        chk("mr_busy", 32'(busy_v[0]), 32'd0);
        #2 INT = 1'b0;
        na = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (ack_v[0]) na++;
        end
        chk("mr_noack", 32'(na), 32'd0);
        run("mr_rdC", 0, 2, 1'b0, 32'hC, 32'h0, 32'hA5A5A5A5, 1'b0);

        run("l1_wr", 1, 1, 1'b1, 32'h0, 32'h0000005A, 32'h0000005A, 1'b0);
        sweep("l1_sw", 1, 1, 32'h0000005A);
        run("l5_wr", 2, 5, 1'b1, 32'h0, 32'h000000A5, 32'h000000A5, 1'b0);
        sweep("l5_sw", 2, 5, 32'h000000A5);

        run("b_low", 3, 2, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b1);
        run("b_wr", 3, 2, 1'b1, 32'h100, 32'h99, 32'h99, 1'b0);
        run("b_rd", 3, 2, 1'b0, 32'h100, 32'h0, 32'h99, 1'b0);
        run("b_oob", 3, 2, 1'b0, 32'h500, 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
